hs4_sync_rx: RTL and testbench

HS4_SYNC_RX -- requirements
Module: hs4_sync_rx

---
 rtl/hs4_pkg.sv | 16 +
 rtl/sync_ff.sv | 24 ++
 rtl/hs4_sync_rx.sv | 110 +++++++++++
 tb/tb_hs4_sync_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// Shared definitions for the 4-phase to synchronous receiver: FSM encoding and synchronizer depth.
// Defining HS4_SYNC_RX_SYNC3_EN selects a 3-stage synchronizer instead of the default 2 stages.
package hs4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

`ifdef HS4_SYNC_RX_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal; all stages clear to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_sync_rx.sv
// 4-phase bundled-data receiver: synchronizes req_in, acknowledges upstream and buffers words in a FIFO.
// Synchronizer depth is 2 by default, 3 when HS4_SYNC_RX_SYNC3_EN is defined.
module hs4_sync_rx
    import hs4_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_in,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          ack_out,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic              req_s;
    state_t            state_q;
    state_t            state_d;
    logic              push;
    logic              pop;
    logic              full;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_s)
    );

    // Full is judged on the level before any same-edge pop.
    assign full = (level_q == FULL_LVL);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    state_d = ACK;
                    push    = 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: storage is left unreset; its contents are only visible while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign ack_out    = (state_q == ACK);
    assign out_valid  = (level_q != '0);
    assign out_data   = mem[rd_ptr];
    assign fifo_level = level_q;

endmodule

// File: tb/tb_hs4_sync_rx.sv
// Self-checking bench for hs4_sync_rx: latency, table-driven transfers, corner sequences and random traffic.
module tb_hs4_sync_rx;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef HS4_SYNC_RX_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic              clk;
    logic              rst;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        fifo_level;

    int errors = 0;
    int checks = 0;

    hs4_sync_rx #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        logic       pop;
        logic [2:0] exp_level;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input logic val, input string name);
        int n = 0;
        while (ack_out !== val && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, ack_out, val);
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic handshake(input logic [7:0] d, input string name);
        @(negedge clk);
        data_in = d;
        req_in  = 1'b1;
        wait_ack(1'b1, {name, "_ack_hi"});
        req_in = 1'b0;
        wait_ack(1'b0, {name, "_ack_lo"});
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            pop_one();
        end
        check("drain_level", fifo_level, 0);
    endtask

    logic [7:0] q [$];
    logic [7:0] rdata;
    logic       ack_prev;
    int         gap;
    int         pre_size;
    int         nhs;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 3'd1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 3'd2, 8'hA5};
        vecs[2] = '{8'h7E, 1'b1, 3'd2, 8'h3C};
        vecs[3] = '{8'h00, 1'b1, 3'd2, 8'h7E};
        vecs[4] = '{8'hFF, 1'b1, 3'd2, 8'h00};

        rst       = 1'b0;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        rst = 1'b1;

        // Single transfer with edge-accurate latency on both request edges
        @(negedge clk);
        data_in = 8'hA5;
        req_in  = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_rise_e%0d", e), ack_out, (e >= LAT));
        end
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        @(negedge clk);
        req_in = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_fall_e%0d", e), ack_out, (e < LAT));
        end
        drain();

        // Table-driven transfers with optional pop
        for (int i = 0; i < 5; i++) begin
            handshake(vecs[i].data, $sformatf("vec%0d", i));
            if (vecs[i].pop) pop_one();
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
            check($sformatf("vec%0d_head", i), out_data, vecs[i].exp_head);
        end
        drain();

        // Fill to full, fifth request must stall until a pop frees a slot
        for (int i = 1; i <= 4; i++) handshake(8'(i), $sformatf("fill%0d", i));
        check("fill_level", fifo_level, 4);
        @(negedge clk);
        data_in = 8'h05;
        req_in  = 1'b1;
        repeat (10) @(negedge clk);
        check("fill_stall_ack", ack_out, 0);
        check("fill_stall_level", fifo_level, 4);
        check("fill_head", out_data, 8'h01);
        pop_one();
        @(negedge clk);
        wait_ack(1'b1, "fill5_ack_hi");
        req_in = 1'b0;
        wait_ack(1'b0, "fill5_ack_lo");
        check("fill5_level", fifo_level, 4);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("fill_order%0d", i), out_data, i);
            pop_one();
        end
        check("fill_empty", fifo_level, 0);

        // Push and pop on the same edge
        handshake(8'h11, "sim_a");
        handshake(8'h22, "sim_b");
        @(negedge clk);
        data_in = 8'h33;
        req_in  = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("sim_ack", ack_out, 1);
        check("sim_level", fifo_level, 2);
        check("sim_head", out_data, 8'h22);
        req_in = 1'b0;
        wait_ack(1'b0, "sim_ack_lo");
        pop_one();
        check("sim_tail", out_data, 8'h33);
        drain();

        // Reset in the middle of a handshake
        handshake(8'hB1, "rm_a");
        handshake(8'hB2, "rm_b");
        @(negedge clk);
        data_in = 8'hB3;
        req_in  = 1'b1;
        wait_ack(1'b1, "rm_c_ack");
        check("rm_level_pre", fifo_level, 3);
        #2;
        rst = 1'b0;
        #1;
        check("rm_ack_async", ack_out, 0);
        check("rm_level_async", fifo_level, 0);
        check("rm_valid_async", out_valid, 0);
        data_in = 8'h55;
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("rm_rise_e%0d", e), ack_out, (e >= LAT));
        end
        check("rm_new_level", fifo_level, 1);
        check("rm_new_head", out_data, 8'h55);
        @(negedge clk);
        req_in = 1'b0;
        wait_ack(1'b0, "rm_ack_lo");
        drain();

        // Long request produces a single write
        @(negedge clk);
        data_in = 8'h66;
        req_in  = 1'b1;
        repeat (20) @(negedge clk);
        check("long_ack", ack_out, 1);
        check("long_level", fifo_level, 1);
        req_in = 1'b0;
        wait_ack(1'b0, "long_ack_lo");
        repeat (5) @(negedge clk);
        check("long_level_after", fifo_level, 1);
        check("long_head", out_data, 8'h66);
        drain();

        // Random traffic against an ordered-queue model
        q.delete();
        ack_prev = ack_out;
        gap = 0;
        nhs = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            check("rnd_level", fifo_level, q.size());
            check("rnd_valid", out_valid, (q.size() != 0));
            if (q.size() != 0) begin
                rdata = q[0];
                check("rnd_data", out_data, rdata);
            end
            if (req_in && ack_out) begin
                req_in = 1'b0;
            end else if (!req_in && !ack_out) begin
                if (gap == 0) begin
                    data_in = 8'($urandom);
                    req_in  = 1'b1;
                    gap     = $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
            out_ready = ($urandom_range(0, 2) == 0);
            pre_size  = q.size();
            @(posedge clk);
            #1;
            if (out_ready && pre_size != 0) void'(q.pop_front());
            if (ack_out && !ack_prev) begin
                check("rnd_full_block", (pre_size < DEPTH), 1);
                q.push_back(data_in);
                nhs++;
            end
            ack_prev = ack_out;
        end
        out_ready = 1'b0;
        check("rnd_progress", (nhs >= 50), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
